// File: rtl/moddown_scale_pkg.sv
// Shared residue and product types for the ModDown scaling stage.
package moddown_scale_pkg;
    localparam int RNS_WIDTH = 16;

    typedef logic [RNS_WIDTH-1:0]   rns_residue_t;
    typedef logic [2*RNS_WIDTH-1:0] rns_product_t;
endpackage

// File: rtl/moddown_scale_fifo.sv
// rns_bypass_fifo: circular FIFO holding original B-basis residues until the
// matching converter result arrives. A pop on empty never forwards a same-cycle push.
module rns_bypass_fifo
    import moddown_scale_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LANES = 2,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  rns_residue_t [LANES-1:0] data_i,
    output rns_residue_t [LANES-1:0] head_o,
    output logic                     pop_ok_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [PW:0]              count_o,
    output logic                     overflow_o,
    output logic                     underflow_o
);
    rns_residue_t [LANES-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          push_ok_s;

    // Full-FIFO push succeeds only when a real pop frees the slot this cycle.
    always_comb begin
        empty_o     = (count_q == {(PW+1){1'b0}});
        full_o      = (count_q == (PW+1)'(DEPTH));
        pop_ok_o    = pop_i & ~empty_o;
        push_ok_s   = push_i & (~full_o | pop_ok_o);
        overflow_o  = push_i & full_o & ~pop_ok_o;
        underflow_o = pop_i & empty_o;
        head_o      = mem_q[rd_ptr_q];
        count_o     = count_q;
        wr_ptr_d    = push_ok_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d    = pop_ok_o  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        case ({push_ok_s, pop_ok_o})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {(PW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; stale contents are harmless once the pointers reset.
    always_ff @(posedge clk_i) begin
        if (push_ok_s && !reset_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end
endmodule

// File: rtl/moddown_scale.sv
// moddown_scale: (x_b - conv_b) * q^-1 mod b per lane, two-stage pipeline.
// Build option MODDOWN_STICKY_ERR_EN makes the error flags sticky until reset.
module moddown_scale
    import moddown_scale_pkg::*;
#(
    parameter int           BASIS_LEN             = 2,
    parameter rns_residue_t BASIS     [BASIS_LEN] = '{16'd13, 16'd17},
    parameter rns_residue_t QINV_MODB [BASIS_LEN] = '{16'd5, 16'd14},
    parameter int           FIFO_DEPTH            = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         byp_valid,
    input  rns_residue_t [BASIS_LEN-1:0] byp_RNSint,
    input  logic                         conv_valid,
    input  rns_residue_t [BASIS_LEN-1:0] conv_RNSint,
    output logic                         out_valid,
    output rns_residue_t [BASIS_LEN-1:0] output_RNSint,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overflow_err,
    output logic                         underflow_err
);
    rns_residue_t [BASIS_LEN-1:0] head_s;
    logic                         pop_ok_s, full_s, empty_s, ovf_s, udf_s;

    logic                         s1_valid_q, s1_valid_d;
    rns_residue_t [BASIS_LEN-1:0] s1_diff_q, s1_diff_d;
    logic                         out_valid_q, out_valid_d;
    rns_residue_t [BASIS_LEN-1:0] out_data_q, out_data_d;
    logic                         ovf_q, ovf_d, udf_q, udf_d;

    rns_bypass_fifo #(.DEPTH(FIFO_DEPTH), .LANES(BASIS_LEN)) u_fifo (
        .clk_i       (clk),
        .reset_i     (reset),
        .push_i      (byp_valid),
        .pop_i       (conv_valid),
        .data_i      (byp_RNSint),
        .head_o      (head_s),
        .pop_ok_o    (pop_ok_s),
        .full_o      (full_s),
        .empty_o     (empty_s),
        .count_o     (fifo_count),
        .overflow_o  (ovf_s),
        .underflow_o (udf_s)
    );

    // Both stages; the product is widened so the modulo sees the exact value.
    always_comb begin
        rns_product_t prod_v;
        prod_v      = {(2*RNS_WIDTH){1'b0}};
        s1_valid_d  = pop_ok_s;
        s1_diff_d   = s1_diff_q;
        out_valid_d = s1_valid_q;
        out_data_d  = out_data_q;
        for (int j = 0; j < BASIS_LEN; j++) begin
            if (!pop_ok_s) begin
                s1_diff_d[j] = s1_diff_q[j];
            end else if (head_s[j] >= conv_RNSint[j]) begin
                s1_diff_d[j] = head_s[j] - conv_RNSint[j];
            end else begin
                s1_diff_d[j] = head_s[j] + BASIS[j] - conv_RNSint[j];
            end
            prod_v = rns_product_t'(s1_diff_q[j]) * rns_product_t'(QINV_MODB[j]);
            if (s1_valid_q) begin
                out_data_d[j] = rns_residue_t'(prod_v % rns_product_t'(BASIS[j]));
            end else begin
                out_data_d[j] = out_data_q[j];
            end
        end
`ifdef MODDOWN_STICKY_ERR_EN
        ovf_d = ovf_q | ovf_s;
        udf_d = udf_q | udf_s;
`else
        ovf_d = ovf_s;
        udf_d = udf_s;
`endif
    end

    // Pipeline and flag registers; reset drops any in-flight result.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_diff_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_diff_q   <= s1_diff_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign output_RNSint = out_data_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = udf_q;
endmodule

// File: tb/tb_moddown_scale.sv
// Directed self-checking bench for moddown_scale with B = {13,17}, QINV = {5,14}.
module tb_moddown_scale;
    import moddown_scale_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 byp_valid, conv_valid;
    rns_residue_t [1:0]   byp_RNSint, conv_RNSint;
    logic                 out_valid;
    rns_residue_t [1:0]   output_RNSint;
    logic [2:0]           fifo_count;
    logic                 overflow_err, underflow_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int b0, b1, c0, c1, e0, e1;
    } vec_t;
    vec_t vecs [5];

    moddown_scale dut (
        .clk           (clk),
        .reset         (reset),
        .byp_valid     (byp_valid),
        .byp_RNSint    (byp_RNSint),
        .conv_valid    (conv_valid),
        .conv_RNSint   (conv_RNSint),
        .out_valid     (out_valid),
        .output_RNSint (output_RNSint),
        .fifo_count    (fifo_count),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input int e0, input int e1);
        chk({nm, " valid"}, int'(out_valid), 1);
        chk({nm, " lane0"}, int'(output_RNSint[0]), e0);
        chk({nm, " lane1"}, int'(output_RNSint[1]), e1);
    endtask

    task automatic idle();
        byp_valid  = 1'b0;
        conv_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic push(input int a, input int b);
        byp_valid     = 1'b1;
        byp_RNSint[0] = rns_residue_t'(a);
        byp_RNSint[1] = rns_residue_t'(b);
        tick();
        byp_valid = 1'b0;
    endtask

    // Pop with a given conversion result and verify the two-cycle latency.
    task automatic pop_check(input string nm, input int c0, input int c1, input int e0, input int e1);
        conv_valid     = 1'b1;
        conv_RNSint[0] = rns_residue_t'(c0);
        conv_RNSint[1] = rns_residue_t'(c1);
        tick();
        conv_valid = 1'b0;
        chk({nm, " early valid"}, int'(out_valid), 0);
        tick();
        chk_out(nm, e0, e1);
    endtask

    initial begin
        vecs[0] = '{b0: 10, b1: 3,  c0: 4,  c1: 9,  e0: 4, e1: 1};
        vecs[1] = '{b0: 7,  b1: 16, c0: 7,  c1: 16, e0: 0, e1: 0};
        vecs[2] = '{b0: 12, b1: 0,  c0: 0,  c1: 16, e0: 8, e1: 14};
        vecs[3] = '{b0: 0,  b1: 0,  c0: 12, c1: 16, e0: 5, e1: 14};
        vecs[4] = '{b0: 3,  b1: 4,  c0: 0,  c1: 0,  e0: 2, e1: 5};
        byp_RNSint  = '0;
        conv_RNSint = '0;

        // Reset state
        do_reset();
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst lane0", int'(output_RNSint[0]), 0);
        chk("rst lane1", int'(output_RNSint[1]), 0);
        chk("rst count", int'(fifo_count), 0);
        chk("rst ovf", int'(overflow_err), 0);
        chk("rst udf", int'(underflow_err), 0);

        // Table-driven single operands, conv two cycles after push
        for (int i = 0; i < 5; i++) begin
            push(vecs[i].b0, vecs[i].b1);
            chk($sformatf("vec%0d count", i), int'(fifo_count), 1);
            tick();
            pop_check($sformatf("vec%0d", i), vecs[i].c0, vecs[i].c1, vecs[i].e0, vecs[i].e1);
            tick();
            chk($sformatf("vec%0d pulse", i), int'(out_valid), 0);
            chk($sformatf("vec%0d hold0", i), int'(output_RNSint[0]), vecs[i].e0);
        end

        // Fill then drain back-to-back
        do_reset();
        for (int k = 0; k < 4; k++) push(k, k);
        chk("fill count", int'(fifo_count), 4);
        conv_RNSint = '0;
        for (int i = 0; i < 6; i++) begin
            conv_valid = (i < 4);
            tick();
            case (i)
                1:       chk_out("drain0", 0, 0);
                2:       chk_out("drain1", 5, 14);
                3:       chk_out("drain2", 10, 11);
                4:       chk_out("drain3", 2, 8);
                default: chk($sformatf("drain idle%0d", i), int'(out_valid), 0);
            endcase
        end
        conv_valid = 1'b0;
        chk("drain count", int'(fifo_count), 0);

        // Full with simultaneous push and pop, then overflow
        do_reset();
        push(1, 2); push(3, 4); push(5, 6); push(7, 8);
        byp_valid = 1'b1; byp_RNSint[0] = 16'd9; byp_RNSint[1] = 16'd10;
        conv_valid = 1'b1; conv_RNSint = '0;
        tick();
        idle();
        chk("pushpop count", int'(fifo_count), 4);
        chk("pushpop ovf", int'(overflow_err), 0);
        tick();
        chk_out("pushpop out", 5, 11);
        push(12, 12);
        chk("ovf flag", int'(overflow_err), 1);
        chk("ovf count", int'(fifo_count), 4);
        tick();
`ifdef MODDOWN_STICKY_ERR_EN
        chk("ovf sticky", int'(overflow_err), 1);
`else
        chk("ovf pulse", int'(overflow_err), 0);
`endif
        pop_check("ovf head", 0, 0, 2, 5);
        pop_check("ovf next1", 0, 0, 12, 16);
        pop_check("ovf next2", 0, 0, 9, 10);
        pop_check("ovf next3", 0, 0, 6, 4);
        chk("ovf drained", int'(fifo_count), 0);

        // Underflow with simultaneous push into an empty FIFO
        do_reset();
        byp_valid = 1'b1; byp_RNSint[0] = 16'd4; byp_RNSint[1] = 16'd4;
        conv_valid = 1'b1; conv_RNSint = '0;
        tick();
        idle();
        chk("udf flag", int'(underflow_err), 1);
        chk("udf count", int'(fifo_count), 1);
        chk("udf s1", int'(out_valid), 0);
        tick();
        chk("udf no out", int'(out_valid), 0);
`ifdef MODDOWN_STICKY_ERR_EN
        chk("udf sticky", int'(underflow_err), 1);
`else
        chk("udf pulse", int'(underflow_err), 0);
`endif
        pop_check("udf stored", 0, 0, 7, 5);

        // Reset mid-flight: two queued, one in stage 1, flag raised earlier
        do_reset();
        conv_valid = 1'b1; conv_RNSint = '0;
        tick();
        idle();
        push(1, 1); push(2, 2); push(3, 3);
        conv_valid = 1'b1;
        tick();
        idle();
        chk("mid count", int'(fifo_count), 2);
`ifdef MODDOWN_STICKY_ERR_EN
        chk("mid udf sticky", int'(underflow_err), 1);
`endif
        reset = 1'b1;
        byp_valid = 1'b1;
        tick();
        chk("mid rst out_valid", int'(out_valid), 0);
        chk("mid rst count", int'(fifo_count), 0);
        chk("mid rst udf", int'(underflow_err), 0);
        chk("mid rst ovf", int'(overflow_err), 0);
        reset = 1'b0;
        byp_valid = 1'b0;
        tick();
        chk("mid post out_valid", int'(out_valid), 0);
        chk("mid post count", int'(fifo_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/moddown_scale.md
# moddown_scale

Streaming ModDown scaling stage directly downstream of `fastBConvSingle`. Holds each operand's original residues in the auxiliary basis B while their fast base conversion is in flight. When the conversion result arrives it outputs, per lane j, (x_bj − conv_bj)·(q⁻¹ mod bj) mod bj. Fully pipelined: one result per cycle, no backpressure, matching the valid-only protocol of the converter.

## Interface

Parameters:
- `BASIS_LEN`, 2: number of lanes (moduli bj); equals the converter's `OUT_BASIS_LEN`.
- `BASIS`, '{13,17}: moduli bj, type `rns_residue_t [BASIS_LEN]`.
- `QINV_MODB`, '{5,14}: (q mod bj)⁻¹ mod bj per lane.
- `FIFO_DEPTH`, 4: bypass FIFO entries, power of two, ≥2.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `byp_valid` in 1: push `byp_RNSint` into the bypass FIFO.
- `byp_RNSint` in `rns_residue_t [BASIS_LEN]`: original residues of x in B; each lane < bj.
- `conv_valid` in 1: converter result valid; connects to the converter's `out_valid`.
- `conv_RNSint` in `rns_residue_t [BASIS_LEN]`: converter `output_RNSint`.
- `out_valid` out 1: result valid, one-cycle pulse per result.
- `output_RNSint` out `rns_residue_t [BASIS_LEN]`: scaled residues.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current occupancy.
- `overflow_err` out 1: push dropped because FIFO was full.
- `underflow_err` out 1: `conv_valid` arrived with FIFO empty.

## Operation

- Bypass FIFO is circular, with write/read pointers and a count; the nth push pairs with the nth `conv_valid`, in order.
- Push when `byp_valid`:
  - FIFO not full: store the entry.
  - FIFO full and no simultaneous pop: drop the entry, raise `overflow_err`, leave contents unchanged.
  - FIFO full with a simultaneous pop: both operations succeed, no error, count unchanged.
- Pop when `conv_valid`:
  - FIFO non-empty: pop the head entry.
  - FIFO empty: raise `underflow_err`, discard `conv_RNSint`, produce no result.
  - A same-cycle push into an empty FIFO is not forwarded; the push is stored and the pop still underflows.
- Stage 1 (registered on pop), per lane: d = byp ≥ conv ? byp − conv : byp + bj − conv. Width stays `rns_residue_t`; no overflow because both operands are < bj.
- Stage 2 (registered), per lane: out = (d · QINV_MODB[j]) % bj. The product is computed at 2× residue width before the modulo.
- Pointers wrap modulo FIFO_DEPTH.

## Timing

- Latency: `conv_valid` in cycle N produces `out_valid` in cycle N+2.
- Throughput: one result per cycle with back-to-back `conv_valid`.
- `output_RNSint` holds its last value when `out_valid` = 0.
- Reset values: `out_valid` 0, `output_RNSint` all 0, `fifo_count` 0, both error flags 0, pointers 0, stage valids 0.
- Reset mid-operation: FIFO contents are discarded and in-flight pipeline results are dropped. No `out_valid` is produced in the cycle after reset, even if one was pending.
- Inputs sampled while `reset` = 1 are ignored.

## Configuration

- `MODDOWN_STICKY_ERR_EN`:
  - Defined: `overflow_err` and `underflow_err` are sticky and clear only on `reset`.
  - Undefined: each flag is a one-cycle pulse in the cycle after the offending event.
- The datapath is identical in both cases.

## Structure

- The shared package holds `rns_residue_t`, its width constant, and the double-width product type `rns_product_t`.
- Natural sub-module: `rns_bypass_fifo`, parameterised by depth and lane count. It provides push, pop, full, empty, count and the overflow/underflow conditions.
- The two arithmetic stages stay in `moddown_scale`.

## Test plan

All scenarios use the defaults: B = {13,17}, QINV = {5,14}.
- Single operand: push byp = {10,3}; two cycles later conv = {4,9}. Expect `out_valid` exactly 2 cycles after `conv_valid` with output = {4,1} (d = {6,11}).
- Equal operands: byp = {7,16}, conv = {7,16}. Expect output {0,0}.
- Fill and drain:
  - Push 4 entries {0,0}, {1,1}, {2,2}, {3,3} back-to-back; `fifo_count` reaches 4.
  - Then apply 4 consecutive conv = {0,0}.
  - Expect outputs {0,0}, {5,14}, {10,11}, {2,8} on consecutive cycles, in order.
- Full boundary:
  - With FIFO full, a 5th push alone sets `overflow_err`, and the next pop returns the original head.
  - With FIFO full, a push and pop in the same cycle produce no error and `fifo_count` stays 4.
- Underflow: `conv_valid` with the FIFO empty (even with a simultaneous push) sets `underflow_err`, produces no `out_valid`, and leaves `fifo_count` = 1 afterwards.
- Reset mid-flight:
  - Setup: 2 entries queued and one result in stage 1; assert `reset` for one cycle.
  - Expect `out_valid` to stay 0, `fifo_count` = 0 and flags cleared.
  - Run the sticky-flag variant with and without `MODDOWN_STICKY_ERR_EN`.
